// File: rtl/dualmem_widen_pipe_pkg.sv
// Shared types and lane helpers for the narrow/wide dual-port buffer.
package dualmem_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // Byte offset of a narrow lane inside a wide word.
  function automatic int unsigned lane_shift(input int unsigned lane, input int unsigned lane_bytes);
    return lane * lane_bytes;
  endfunction

endpackage

// File: rtl/dualmem_widen_pipe_if.sv
// Access bundle for the two RAM ports plus the clear-engine control pair.
interface dualmem_widen_pipe_if #(
  parameter int unsigned NARROW_W = 16,
  parameter int unsigned RATIO    = 4,
  parameter int unsigned DEPTH    = 2048
);
  localparam int unsigned WIDE_W = NARROW_W * RATIO;
  localparam int unsigned AWB    = $clog2(DEPTH);
  localparam int unsigned AWA    = AWB + $clog2(RATIO);

  logic                  clr_req;
  logic                  busy;
  logic                  ena;
  logic [NARROW_W/8-1:0] wea;
  logic [AWA-1:0]        addra;
  logic [NARROW_W-1:0]   dina;
  logic [NARROW_W-1:0]   douta;
  logic                  valida;
  logic                  enb;
  logic [WIDE_W/8-1:0]   web;
  logic [AWB-1:0]        addrb;
  logic [WIDE_W-1:0]     dinb;
  logic [WIDE_W-1:0]     doutb;
  logic                  validb;

  modport master (
    output clr_req, ena, wea, addra, dina, enb, web, addrb, dinb,
    input  busy, douta, valida, doutb, validb
  );

  modport slave (
    input  clr_req, ena, wea, addra, dina, enb, web, addrb, dinb,
    output busy, douta, valida, doutb, validb
  );
endinterface

// File: rtl/dualmem_widen_pipe_bram_core.sv
// Byte-write true-dual-port array, read-first on both ports; port B write wins a byte collision.
module dualmem_bram_core #(
  parameter  int unsigned WIDE_W = 64,
  parameter  int unsigned DEPTH  = 2048,
  localparam int unsigned NB     = WIDE_W / 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_rd_i,
  input  logic [NB-1:0]     a_be_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [WIDE_W-1:0] a_din_i,
  output logic [WIDE_W-1:0] a_dout_o,
  input  logic              b_rd_i,
  input  logic [NB-1:0]     b_be_i,
  input  logic [AW-1:0]     b_addr_i,
  input  logic [WIDE_W-1:0] b_din_i,
  output logic [WIDE_W-1:0] b_dout_o
);
  logic [WIDE_W-1:0] mem_q [DEPTH];

  // Port B is applied last so it overrides port A on the same byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (a_be_i[i]) mem_q[a_addr_i][i*8 +: 8] <= a_din_i[i*8 +: 8];
    end
    for (int i = 0; i < NB; i++) begin
      if (b_be_i[i]) mem_q[b_addr_i][i*8 +: 8] <= b_din_i[i*8 +: 8];
    end
  end

  // Read registers only move on reads so the last read data is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dout_o <= '0;
      b_dout_o <= '0;
    end else begin
      if (a_rd_i) a_dout_o <= mem_q[a_addr_i];
      if (b_rd_i) b_dout_o <= mem_q[b_addr_i];
    end
  end
endmodule

// File: rtl/dualmem_widen_pipe.sv
// Narrow/wide dual-port buffer: lane steering, read-valid pipe, optional output stage, clear engine.
module dualmem_widen_pipe
  import dualmem_pkg::*;
#(
  parameter int unsigned NARROW_W   = 16,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input logic                 clk,
  input logic                 rst,
  dualmem_widen_pipe_if.slave bus
);
  localparam int unsigned WIDE_W = NARROW_W * RATIO;
  localparam int unsigned NBA    = NARROW_W / 8;
  localparam int unsigned NBB    = WIDE_W / 8;
  localparam int unsigned LW     = $clog2(RATIO);
  localparam int unsigned AWB    = $clog2(DEPTH);
  localparam int unsigned AWA    = AWB + LW;

  clr_state_e        state_q;
  logic [AWB-1:0]    cnt_q;
  logic              busy;
  logic              a_rd, b_rd;
  logic [NBB-1:0]    a_be, b_be;
  logic [AWB-1:0]    a_addr, b_addr;
  logic [WIDE_W-1:0] a_din, b_din, a_dout, b_dout;
  logic [LW-1:0]     lane_a;
  logic [LW-1:0]     lane_a_q;
  logic              va1_q, vb1_q;
  logic [NARROW_W-1:0] a_narrow;

  assign busy     = (state_q == CLR_RUN);
  assign bus.busy = busy;

  // Clear engine: one zeroed word per cycle, DEPTH cycles total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? CLR_RUN : CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (bus.clr_req) begin
            state_q <= CLR_RUN;
            cnt_q   <= '0;
          end
        end
        CLR_RUN: begin
          cnt_q <= cnt_q + AWB'(1);
          if (cnt_q == AWB'(DEPTH - 1)) state_q <= CLR_IDLE;
        end
        default: state_q <= CLR_IDLE;
      endcase
    end
  end

  // Request steering; while clearing, user accesses are dropped and port B zeroes the array.
  always_comb begin
    lane_a = bus.addra[LW-1:0];
    a_addr = bus.addra[AWA-1:LW];
    a_din  = {RATIO{bus.dina}};
    a_be   = '0;
    a_rd   = 1'b0;
    b_addr = bus.addrb;
    b_din  = bus.dinb;
    b_be   = '0;
    b_rd   = 1'b0;
    if (bus.ena && !busy) begin
      a_be = NBB'(bus.wea) << lane_shift(32'(lane_a), NBA);
      a_rd = (bus.wea == '0);
    end
    if (busy) begin
      b_addr = cnt_q;
      b_din  = '0;
      b_be   = '1;
    end else if (bus.enb) begin
      b_be = bus.web;
      b_rd = (bus.web == '0);
    end
  end

  dualmem_bram_core #(
    .WIDE_W (WIDE_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .a_rd_i   (a_rd),
    .a_be_i   (a_be),
    .a_addr_i (a_addr),
    .a_din_i  (a_din),
    .a_dout_o (a_dout),
    .b_rd_i   (b_rd),
    .b_be_i   (b_be),
    .b_addr_i (b_addr),
    .b_din_i  (b_din),
    .b_dout_o (b_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va1_q    <= 1'b0;
      vb1_q    <= 1'b0;
      lane_a_q <= '0;
    end else begin
      va1_q <= a_rd;
      vb1_q <= b_rd;
      if (a_rd) lane_a_q <= lane_a;
    end
  end

  assign a_narrow = a_dout[lane_a_q*NARROW_W +: NARROW_W];

  if (OUT_REG != 0) begin : g_oreg
    logic                va2_q, vb2_q;
    logic [NARROW_W-1:0] douta_q;
    logic [WIDE_W-1:0]   doutb_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        va2_q   <= 1'b0;
        vb2_q   <= 1'b0;
        douta_q <= '0;
        doutb_q <= '0;
      end else begin
        va2_q <= va1_q;
        vb2_q <= vb1_q;
        if (va1_q) douta_q <= a_narrow;
        if (vb1_q) doutb_q <= b_dout;
      end
    end

    assign bus.valida = va2_q;
    assign bus.douta  = douta_q;
    assign bus.validb = vb2_q;
    assign bus.doutb  = doutb_q;
  end else begin : g_noreg
    assign bus.valida = va1_q;
    assign bus.douta  = a_narrow;
    assign bus.validb = vb1_q;
    assign bus.doutb  = b_dout;
  end
endmodule

// File: tb/tb_dualmem_widen_pipe.sv
// Bench: OUT_REG=0 and OUT_REG=1 instances on shared stimulus, checked against a word-array model.
module tb_dualmem_widen_pipe;
  localparam int DEPTH = 2048;
  localparam int RATIO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dualmem_widen_pipe_if if0 ();
  dualmem_widen_pipe_if if1 ();

  assign if1.clr_req = if0.clr_req;
  assign if1.ena     = if0.ena;
  assign if1.wea     = if0.wea;
  assign if1.addra   = if0.addra;
  assign if1.dina    = if0.dina;
  assign if1.enb     = if0.enb;
  assign if1.web     = if0.web;
  assign if1.addrb   = if0.addrb;
  assign if1.dinb    = if0.dinb;

  dualmem_widen_pipe #(.OUT_REG(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dualmem_widen_pipe #(.OUT_REG(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  int n_vec = 0;
  int n_err = 0;

  // Reference state: array contents, clear cycles left, expected outputs for each latency.
  logic [63:0] mem_m [DEPTH];
  int          clr_left;
  logic        e0_va, e0_vb, e1_va, e1_vb;
  logic [15:0] e0_da, e1_da;
  logic [63:0] e0_db, e1_db;

  typedef struct {
    logic        ena;
    logic [1:0]  wea;
    logic [12:0] addra;
    logic [15:0] dina;
    logic        enb;
    logic [7:0]  web;
    logic [10:0] addrb;
    logic [63:0] dinb;
    logic        eva;
    logic [15:0] eda;
    logic        evb;
    logic [63:0] edb;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 64'h0;
  endtask

  task automatic drive(input logic ena, input logic [1:0] wea, input logic [12:0] addra,
                       input logic [15:0] dina, input logic enb, input logic [7:0] web,
                       input logic [10:0] addrb, input logic [63:0] dinb);
    if0.ena = ena; if0.wea = wea; if0.addra = addra; if0.dina = dina;
    if0.enb = enb; if0.web = web; if0.addrb = addrb; if0.dinb = dinb;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'b00, 13'h0, 16'h0, 1'b0, 8'h00, 11'h0, 64'h0);
    if0.clr_req = 1'b0;
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
          13'($urandom_range(0, 31)), 16'($urandom),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00,
          11'($urandom_range(0, 7)), {32'($urandom), 32'($urandom)});
  endtask

  task automatic check_outputs();
    chk("valida0", 64'(if0.valida), 64'(e0_va));
    chk("douta0",  64'(if0.douta),  64'(e0_da));
    chk("validb0", 64'(if0.validb), 64'(e0_vb));
    chk("doutb0",  if0.doutb, e0_db);
    chk("valida1", 64'(if1.valida), 64'(e1_va));
    chk("douta1",  64'(if1.douta),  64'(e1_da));
    chk("validb1", 64'(if1.validb), 64'(e1_vb));
    chk("doutb1",  if1.doutb, e1_db);
  endtask

  // One clock: predict from the current inputs, advance, compare both instances.
  task automatic step();
    logic        busy_m, acc_a, acc_b, rd_a, rd_b;
    int          wa, la, wb;
    logic [15:0] ra;
    logic [63:0] rb;
    busy_m = (clr_left != 0);
    chk("busy0", 64'(if0.busy), 64'(busy_m));
    chk("busy1", 64'(if1.busy), 64'(busy_m));
    acc_a = if0.ena && !busy_m;
    acc_b = if0.enb && !busy_m;
    rd_a  = acc_a && (if0.wea == 2'b00);
    rd_b  = acc_b && (if0.web == 8'h00);
    wa = int'(if0.addra) / RATIO;
    la = int'(if0.addra) % RATIO;
    wb = int'(if0.addrb);
    ra = 16'(mem_m[wa] >> (la * 16));
    rb = mem_m[wb];
    if (acc_a)
      for (int i = 0; i < 2; i++)
        if (if0.wea[i]) mem_m[wa][(la*2+i)*8 +: 8] = if0.dina[i*8 +: 8];
    if (acc_b)
      for (int i = 0; i < 8; i++)
        if (if0.web[i]) mem_m[wb][i*8 +: 8] = if0.dinb[i*8 +: 8];
    if (busy_m) clr_left--;
    else if (if0.clr_req) begin
      clr_left = DEPTH;
      clear_model();
    end
    @(posedge clk);
    @(negedge clk);
    e1_va = e0_va;
    e1_vb = e0_vb;
    if (e0_va) e1_da = e0_da;
    if (e0_vb) e1_db = e0_db;
    e0_va = rd_a;
    e0_vb = rd_b;
    if (rd_a) e0_da = ra;
    if (rd_b) e0_db = rb;
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    drive_idle();
    rst = 1'b1;
    #1;
    clear_model();
    clr_left = DEPTH;
    e0_va = 1'b0; e0_vb = 1'b0; e1_va = 1'b0; e1_vb = 1'b0;
    e0_da = '0; e1_da = '0; e0_db = '0; e1_db = '0;
    check_outputs();
    chk("rst_busy0", 64'(if0.busy), 64'd1);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_clear_out(input string name, input int expect_len);
    int k = 0;
    drive_idle();
    while (if0.busy === 1'b1 && k < 3000) begin
      step();
      k++;
    end
    if (expect_len >= 0) chk(name, 64'(k), 64'(expect_len));
    else chk(name, 64'(if0.busy), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 13'd0, 16'h0,    1'b1, 8'h00, 11'd5, 64'h0,
                1'b0, 16'h0,    1'b1, 64'h0};
    tbl[1]  = '{1'b1, 2'b11, 13'd3, 16'hBEEF, 1'b0, 8'h00, 11'd0, 64'h0,
                1'b0, 16'h0,    1'b0, 64'h0};
    tbl[2]  = '{1'b0, 2'b00, 13'd0, 16'h0,    1'b1, 8'h00, 11'd0, 64'h0,
                1'b0, 16'h0,    1'b1, 64'hBEEF_0000_0000_0000};
    tbl[3]  = '{1'b0, 2'b00, 13'd0, 16'h0,    1'b1, 8'h0F, 11'd1, 64'h0123_4567_89AB_CDEF,
                1'b0, 16'h0,    1'b0, 64'hBEEF_0000_0000_0000};
    tbl[4]  = '{1'b1, 2'b00, 13'd4, 16'h0,    1'b0, 8'h00, 11'd0, 64'h0,
                1'b1, 16'hCDEF, 1'b0, 64'hBEEF_0000_0000_0000};
    tbl[5]  = '{1'b1, 2'b00, 13'd5, 16'h0,    1'b0, 8'h00, 11'd0, 64'h0,
                1'b1, 16'h89AB, 1'b0, 64'hBEEF_0000_0000_0000};
    tbl[6]  = '{1'b1, 2'b00, 13'd6, 16'h0,    1'b0, 8'h00, 11'd0, 64'h0,
                1'b1, 16'h0000, 1'b0, 64'hBEEF_0000_0000_0000};
    tbl[7]  = '{1'b1, 2'b11, 13'd0, 16'h1111, 1'b1, 8'hFF, 11'd0, 64'h2222_2222_2222_2222,
                1'b0, 16'h0000, 1'b0, 64'hBEEF_0000_0000_0000};
    tbl[8]  = '{1'b1, 2'b00, 13'd0, 16'h0,    1'b1, 8'h00, 11'd0, 64'h0,
                1'b1, 16'h2222, 1'b1, 64'h2222_2222_2222_2222};
    tbl[9]  = '{1'b1, 2'b00, 13'd0, 16'h0,    1'b1, 8'h03, 11'd0, 64'h0000_0000_0000_AAAA,
                1'b1, 16'h2222, 1'b0, 64'h2222_2222_2222_2222};
    tbl[10] = '{1'b1, 2'b00, 13'd0, 16'h0,    1'b0, 8'h00, 11'd0, 64'h0,
                1'b1, 16'hAAAA, 1'b0, 64'h2222_2222_2222_2222};
    tbl[11] = '{1'b1, 2'b01, 13'd1, 16'h5577, 1'b0, 8'h00, 11'd0, 64'h0,
                1'b0, 16'hAAAA, 1'b0, 64'h2222_2222_2222_2222};
    tbl[12] = '{1'b1, 2'b00, 13'd1, 16'h0,    1'b1, 8'h00, 11'd0, 64'h0,
                1'b1, 16'h2277, 1'b1, 64'h2222_2222_2277_AAAA};
    tbl[13] = '{1'b1, 2'b11, 13'd0, 16'h1234, 1'b1, 8'h00, 11'd0, 64'h0,
                1'b0, 16'h2277, 1'b1, 64'h2222_2222_2277_AAAA};

    drive_idle();
    @(negedge clk);
    do_reset(3);
    run_clear_out("post_reset_busy_len", DEPTH);

    // Directed vectors with fixed expectations for the latency-1 instance.
    for (int v = 0; v < 14; v++) begin
      drive(tbl[v].ena, tbl[v].wea, tbl[v].addra, tbl[v].dina,
            tbl[v].enb, tbl[v].web, tbl[v].addrb, tbl[v].dinb);
      step();
      chk($sformatf("tbl%0d_valida", v), 64'(if0.valida), 64'(tbl[v].eva));
      chk($sformatf("tbl%0d_douta", v),  64'(if0.douta),  64'(tbl[v].eda));
      chk($sformatf("tbl%0d_validb", v), 64'(if0.validb), 64'(tbl[v].evb));
      chk($sformatf("tbl%0d_doutb", v),  if0.doutb, tbl[v].edb);
    end

    // Randomised traffic over a small address window, occasional clears.
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      if0.clr_req = ($urandom_range(0, 699) == 0);
      step();
    end
    run_clear_out("random_idle_timeout", -1);

    // Latency-2 instance: valid two cycles after accept.
    drive(1'b1, 2'b11, 13'd9, 16'hC0DE, 1'b0, 8'h00, 11'd0, 64'h0);
    step();
    drive(1'b1, 2'b00, 13'd9, 16'h0, 1'b0, 8'h00, 11'd0, 64'h0);
    step();
    chk("oreg_n1_valida0", 64'(if0.valida), 64'd1);
    chk("oreg_n1_valida1", 64'(if1.valida), 64'd0);
    drive_idle();
    step();
    chk("oreg_n2_valida1", 64'(if1.valida), 64'd1);
    chk("oreg_n2_douta1",  64'(if1.douta),  64'hC0DE);

    // Requests during a clear are dropped and leave the array zeroed.
    if0.clr_req = 1'b1;
    step();
    drive(1'b1, 2'b11, 13'd8, 16'hFFFF, 1'b1, 8'hFF, 11'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("busy_drop_valida", 64'(if0.valida), 64'd0);
    drive(1'b1, 2'b00, 13'd8, 16'h0, 1'b1, 8'h00, 11'd2, 64'h0);
    step();
    chk("busy_drop_validb", 64'(if0.validb), 64'd0);
    run_clear_out("busy_len_clr_req", DEPTH - 2);
    drive(1'b1, 2'b00, 13'd8, 16'h0, 1'b1, 8'h00, 11'd2, 64'h0);
    step();
    chk("after_clr_douta", 64'(if0.douta), 64'h0);
    chk("after_clr_doutb", if0.doutb, 64'h0);
    chk("after_clr_validb", 64'(if0.validb), 64'd1);

    // Reset with a latency-2 read still in flight.
    drive(1'b1, 2'b00, 13'd9, 16'h0, 1'b1, 8'h00, 11'd2, 64'h0);
    step();
    do_reset(2);
    run_clear_out("rst_mid_read_busy_len", DEPTH);

    // Clear started mid-traffic, then reset at clear count 100.
    drive_random();
    if0.clr_req = 1'b1;
    step();
    for (int n = 0; n < 100; n++) begin
      drive_random();
      if0.clr_req = 1'b0;
      step();
    end
    do_reset(1);
    run_clear_out("rst_mid_clear_busy_len", DEPTH);
    for (int n = 0; n < 40; n++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
